// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one external W-bit PISO between N_REQ byte clients.
// Drives the PISO load/reset controls and produces a valid/last/id qualifier aligned to its serial output.
module piso_tx_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int GAP   = 0,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               piso_rst,
  output logic               piso_load,
  output logic [W-1:0]       piso_pi,
  output logic               sout_valid,
  output logic               sout_last,
  output logic [IDW-1:0]     sout_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int              CW       = $clog2(W + 16);
  localparam logic [CW-1:0]   LAST_BIT = CW'(W - 1);
  localparam logic [CW-1:0]   LAST_GAP = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [IDW:0]    N_EXT    = (IDW + 1)'(N_REQ);
  localparam logic [N_REQ-1:0] OH_ONE  = {{(N_REQ - 1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              piso_rst_q, piso_rst_d;
  logic              piso_load_q, piso_load_d;
  logic [W-1:0]      piso_pi_q, piso_pi_d;
  logic              sout_valid_q, sout_valid_d;
  logic              sout_last_q, sout_last_d;
  logic [IDW-1:0]    sout_id_q, sout_id_d;

  logic [IDW:0]      cand_s;
  logic              win_found_s;
  logic [IDW-1:0]    win_idx_s;
  logic [IDW:0]      rr_inc_s;
  logic [N_REQ-1:0]  win_oh_s;

  // Round-robin search: first requester at or above the pointer, wrapping at N_REQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, rr_q} + (IDW + 1)'(i);
      cand_s = (cand_s >= N_EXT) ? (cand_s - N_EXT) : cand_s;
      if (!win_found_s && req[cand_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
    rr_inc_s = {1'b0, win_idx_s} + (IDW + 1)'(1);
    win_oh_s = OH_ONE << win_idx_s;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic; the counter runs the SHIFT bits and then the WAIT gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s && !piso_rst_q) begin
          state_d = ST_LOAD;
          owner_d = win_idx_s;
          rr_d    = (rr_inc_s == N_EXT) ? '0 : rr_inc_s[IDW-1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d = (GAP > 0) ? ST_WAIT : ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_GAP) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values; the serial qualifier is the SHIFT flag delayed one cycle.
  always_comb begin
    ack_d        = '0;
    grant_d      = grant_q;
    piso_load_d  = 1'b0;
    piso_pi_d    = piso_pi_q;
    piso_rst_d   = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    sout_valid_d = (state_q == ST_SHIFT);
    sout_last_d  = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);
    sout_id_d    = sout_id_q;
    if (state_q == ST_IDLE && state_d == ST_LOAD) begin
      ack_d       = win_oh_s;
      grant_d     = win_oh_s;
      piso_load_d = 1'b1;
      piso_pi_d   = data[win_idx_s*W +: W];
    end else if (state_q == ST_SHIFT && state_d != ST_SHIFT) begin
      grant_d = '0;
    end else begin
      grant_d = grant_q;
    end
    if (state_q == ST_SHIFT && cnt_q == '0) begin
      sout_id_d = owner_q;
    end else begin
      sout_id_d = sout_id_q;
    end
  end

  // Registered outputs; piso_rst stays high until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      piso_rst_q   <= 1'b1;
      piso_load_q  <= 1'b0;
      piso_pi_q    <= '0;
      sout_valid_q <= 1'b0;
      sout_last_q  <= 1'b0;
      sout_id_q    <= '0;
    end else begin
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      piso_rst_q   <= piso_rst_d;
      piso_load_q  <= piso_load_d;
      piso_pi_q    <= piso_pi_d;
      sout_valid_q <= sout_valid_d;
      sout_last_q  <= sout_last_d;
      sout_id_q    <= sout_id_d;
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign piso_rst   = piso_rst_q;
  assign piso_load  = piso_load_q;
  assign piso_pi    = piso_pi_q;
  assign sout_valid = sout_valid_q;
  assign sout_last  = sout_last_q;
  assign sout_id    = sout_id_q;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Directed bench for piso_tx_sched: a behavioural PISO on its controls, table-driven frames
// plus hand-written sequences for reset, back-to-back arbitration, late requests and the gap.
module tb_piso_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] data = 32'h0;
  logic [3:0]  ack, grant;
  logic        busy, piso_rst, piso_load, sout_valid, sout_last;
  logic [7:0]  piso_pi;
  logic [1:0]  sout_id;

  logic [3:0]  req_g = 4'b0000;
  logic [31:0] data_g = 32'h0;
  logic [3:0]  ack_g, grant_g;
  logic        busy_g, piso_rst_g, piso_load_g, sout_valid_g, sout_last_g;
  logic [7:0]  piso_pi_g;
  logic [1:0]  sout_id_g;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] pq = 8'h00;
  logic       psout = 1'b0;

  piso_tx_sched #(.N_REQ(4), .W(8), .GAP(0), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack), .grant(grant), .busy(busy),
    .piso_rst(piso_rst), .piso_load(piso_load), .piso_pi(piso_pi),
    .sout_valid(sout_valid), .sout_last(sout_last), .sout_id(sout_id));

  piso_tx_sched #(.N_REQ(4), .W(8), .GAP(3), .IDW(2)) dut_g (
    .clk(clk), .rst(rst), .req(req_g), .data(data_g), .ack(ack_g), .grant(grant_g), .busy(busy_g),
    .piso_rst(piso_rst_g), .piso_load(piso_load_g), .piso_pi(piso_pi_g),
    .sout_valid(sout_valid_g), .sout_last(sout_last_g), .sout_id(sout_id_g));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PISO: sync reset, load, MSB-first shift with a registered serial output.
  always @(posedge clk) begin
    if (piso_rst) begin
      pq    <= 8'h00;
      psout <= 1'b0;
    end else begin
      pq    <= piso_load ? piso_pi : {pq[6:0], 1'b0};
      psout <= pq[7];
    end
  end

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] dt;
    logic [1:0]  id;
    logic [7:0]  byt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Requests one frame, checks the LOAD cycle, then the 8 serial bits and their qualifiers.
  task automatic run_frame(input logic [3:0] rq, input logic [31:0] dt,
                           input logic [1:0] id, input logic [7:0] byt);
    logic [3:0] oh;
    bit got;
    oh  = 4'b0001 << id;
    got = 1'b0;
    req  = rq;
    data = dt;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (piso_load) got = 1'b1;
    end
    chk("frame_load_seen", 32'(got), 32'd1);
    if (got) begin
      chk("frame_ack", 32'(ack), 32'(oh));
      chk("frame_grant", 32'(grant), 32'(oh));
      chk("frame_pi", 32'(piso_pi), 32'(byt));
      chk("frame_busy", 32'(busy), 32'd1);
      req = 4'b0000;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (k >= 2 && k <= 9) begin
          chk("bit_valid", 32'(sout_valid), 32'd1);
          chk("bit_value", 32'(psout), 32'(byt[9-k]));
          chk("bit_last", 32'(sout_last), 32'(k == 9));
          chk("bit_id", 32'(sout_id), 32'(id));
        end else begin
          chk("bit_idle_valid", 32'(sout_valid), 32'd0);
        end
      end
    end
  endtask

  initial begin
    logic [3:0] oh;
    logic [31:0] d;
    logic [7:0] b;
    logic [1:0] wid;
    bit got;
    int last_cyc;
    int nl;

    tbl[0] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5};
    tbl[1] = '{4'b1111, 32'hC311_2233, 2'd3, 8'hC3};
    tbl[2] = '{4'b1010, 32'h4496_550F, 2'd1, 8'h55};
    tbl[3] = '{4'b1011, 32'h7E00_8118, 2'd3, 8'h7E};
    tbl[4] = '{4'b0001, 32'h0000_00E1, 2'd0, 8'hE1};
    tbl[5] = '{4'b0001, 32'h0000_003C, 2'd0, 8'h3C};
    tbl[6] = '{4'b1001, 32'hB200_004D, 2'd3, 8'hB2};
    tbl[7] = '{4'b0110, 32'h0069_D800, 2'd1, 8'hD8};

    // Reset state and release.
    @(negedge clk);
    chk("rst_piso_rst", 32'(piso_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_piso_pi", 32'(piso_pi), 32'd0);
    chk("rst_sout_id", 32'(sout_id), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_piso_rst_held", 32'(piso_rst), 32'd1);
    @(negedge clk);
    chk("release_piso_rst_drop", 32'(piso_rst), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_load", 32'(piso_load), 32'd0);
      chk("idle_valid", 32'(sout_valid), 32'd0);
    end

    // Table-driven frames; pointer evolution is hand-traced in the expected ids.
    for (int v = 0; v < 8; v++) begin
      run_frame(tbl[v].rq, tbl[v].dt, tbl[v].id, tbl[v].byt);
    end

    // Reset in the 4th SHIFT cycle, then a full re-serialisation.
    req = 4'b0001;
    data = 32'h0000_003C;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (piso_load) got = 1'b1;
    end
    chk("mid_load_seen", 32'(got), 32'd1);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("mid_valid_before", 32'(sout_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_load", 32'(piso_load), 32'd0);
    chk("mid_rst_pi", 32'(piso_pi), 32'd0);
    chk("mid_rst_valid", 32'(sout_valid), 32'd0);
    chk("mid_rst_last", 32'(sout_last), 32'd0);
    chk("mid_rst_id", 32'(sout_id), 32'd0);
    chk("mid_rst_piso_rst", 32'(piso_rst), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    chk("no_load_under_piso_rst", 32'(piso_load), 32'd0);
    chk("mid_piso_rst_drop", 32'(piso_rst), 32'd0);
    run_frame(4'b0001, 32'h0000_003C, 2'd0, 8'h3C);

    // All four requesting back to back: 0,1,2,3,0 at 10-cycle spacing.
    do_reset();
    d = 32'h4433_2211;
    data = d;
    req = 4'b1111;
    last_cyc = 0;
    for (int f = 0; f < 5; f++) begin
      wid = 2'(f % 4);
      oh = 4'b0001 << wid;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (piso_load) got = 1'b1;
      end
      chk("rr_load_seen", 32'(got), 32'd1);
      chk("rr_grant", 32'(grant), 32'(oh));
      chk("rr_ack", 32'(ack), 32'(oh));
      chk("rr_stale_valid", 32'(sout_valid), 32'd0);
      b = d[wid*8 +: 8];
      chk("rr_pi", 32'(piso_pi), 32'(b));
      if (f > 0) chk("rr_period", 32'(cyc - last_cyc), 32'd10);
      last_cyc = cyc;
      d[wid*8 +: 8] = b + 8'h80;
      data = d;
      if (f == 4) req = 4'b0000;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        if (k >= 2) begin
          chk("rr_bit_valid", 32'(sout_valid), 32'd1);
          chk("rr_bit_value", 32'(psout), 32'(b[9-k]));
          chk("rr_bit_id", 32'(sout_id), 32'(wid));
        end else begin
          chk("rr_first_cycle_valid", 32'(sout_valid), 32'd0);
        end
      end
    end
    @(negedge clk);
    chk("rr_end_valid", 32'(sout_valid), 32'd0);
    chk("rr_end_busy", 32'(busy), 32'd0);

    // One-cycle req[3] pulse, req[0] raised mid-SHIFT; pointer is at 1 here.
    req = 4'b1000;
    data = 32'hF000_005A;
    @(negedge clk);
    req = 4'b0000;
    chk("late_load", 32'(piso_load), 32'd1);
    chk("late_ack3", 32'(ack), 32'h8);
    chk("late_pi", 32'(piso_pi), 32'hF0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 3) req = 4'b0001;
      chk("late_no_ack0", 32'(ack), 32'd0);
    end
    @(negedge clk);
    chk("late_load0", 32'(piso_load), 32'd1);
    chk("late_ack0", 32'(ack), 32'h1);
    chk("late_pi0", 32'(piso_pi), 32'h5A);
    req = 4'b0000;
    repeat (10) @(negedge clk);

    // GAP=3 instance with req[1] held: LOAD every 13 cycles.
    req_g = 4'b0010;
    data_g = 32'h0000_9900;
    nl = 0;
    last_cyc = 0;
    for (int t = 0; t < 80 && nl < 4; t++) begin
      @(negedge clk);
      if (piso_load_g) begin
        if (nl > 0) chk("gap_period", 32'(cyc - last_cyc), 32'd13);
        else chk("gap_ack", 32'(ack_g), 32'h2);
        last_cyc = cyc;
        nl++;
      end
    end
    chk("gap_loads", 32'(nl), 32'd4);
    req_g = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
